// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers.
// Grant rotates after MAX_BURST words or when the owner drops valid.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   input  logic                          fifo_full,
   output logic                          grant_active,
   output logic [ID_WIDTH-1:0]           grant_id
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] owner_q, owner_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]       burst_q, burst_d;

   logic                xfer;
   logic                own_valid;
   logic [ID_WIDTH-1:0] nxt_ptr;
   logic [ID_WIDTH:0]   win_idle;
   logic [ID_WIDTH:0]   win_rel;
   logic                release_w;

   // First valid requester at or after pointer p, wrapping; MSB = found.
   function automatic logic [ID_WIDTH:0] pick(
      input logic [NUM_REQ-1:0]  v,
      input logic [ID_WIDTH-1:0] p
   );
      logic [ID_WIDTH:0] r;
      int                idx;
      r = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(p) + k) % NUM_REQ;
         if (v[idx]) r = {1'b1, ID_WIDTH'(idx)};
      end
      return r;
   endfunction

   assign grant_active = (state_q == GRANT);
   assign grant_id     = owner_q;
   assign own_valid    = req_valid[owner_q];
   assign nxt_ptr      = ID_WIDTH'((int'(owner_q) + 1) % NUM_REQ);
   assign win_idle     = pick(req_valid, rr_ptr_q);
   assign win_rel      = pick(req_valid, nxt_ptr);

   // Write datapath driven from the registered grant; silenced in reset.
   always_comb begin
      req_ready  = '0;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      xfer       = 1'b0;
      if (grant_active) begin
         fifo_din = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
      end
      if (grant_active && !rst) begin
         req_ready[owner_q] = !fifo_full;
         xfer               = own_valid && !fifo_full;
         fifo_wr_en         = xfer;
      end
   end

   // Next grant: burst counting, release and zero-bubble hand-over.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      burst_d   = burst_q;
      release_w = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_idle[ID_WIDTH]) begin
               state_d = GRANT;
               owner_d = win_idle[ID_WIDTH-1:0];
               burst_d = '0;
            end
         end
         GRANT: begin
            if (xfer) begin
               burst_d = burst_q + CW'(1);
               if (burst_q == LAST) release_w = 1'b1;
            end else if (!own_valid) begin
               release_w = 1'b1;
            end
            if (release_w) begin
               rr_ptr_d = nxt_ptr;
               burst_d  = '0;
               if (win_rel[ID_WIDTH]) begin
                  owner_d = win_rel[ID_WIDTH-1:0];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic,
// checked each cycle against a grant-level reference model.
module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MB = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_din;
   logic            fifo_full;
   logic            grant_active;
   logic [IW-1:0]   grant_id;

   fifo_wr_arbiter #(
      .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
      .grant_active(grant_active), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int d; int cyc;} wr_t;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   logic [7:0] pq[N][$];
   wr_t        log_q[$];

   bit         m_act;
   int         m_own, m_used, m_ptr;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int winner(input int p);
      for (int k = 0; k < N; k++) begin
         if (pq[(p + k) % N].size() > 0) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = pq[i].size() > 0;
         req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
      end
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) pq[i].delete();
      log_q.delete();
   endtask

   task automatic step(input bit r, input bit f);
      logic [N-1:0] e_rdy;
      logic         e_wr;
      logic [7:0]   e_din;
      int           w;
      bit           done;
      rst = r;
      fifo_full = f;
      drive();
      @(negedge clk);
      e_rdy = '0;
      for (int i = 0; i < N; i++)
         e_rdy[i] = !r && m_act && (i == m_own) && !f;
      e_wr  = !r && m_act && (pq[m_own].size() > 0) && !f;
      e_din = (m_act && pq[m_own].size() > 0) ? pq[m_own][0] : 8'h00;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
      chk("fifo_din", 32'(fifo_din), 32'(e_din));
      chk("grant_active", 32'(grant_active), 32'(m_act));
      chk("grant_id", 32'(grant_id), 32'(m_own));
      if (fifo_wr_en === 1'b1)
         log_q.push_back('{int'(grant_id), int'(fifo_din), cyc});
      @(posedge clk);
      if (r) begin
         m_act = 0; m_own = 0; m_used = 0; m_ptr = 0;
      end else if (!m_act) begin
         w = winner(m_ptr);
         if (w >= 0) begin m_act = 1; m_own = w; m_used = 0; end
      end else begin
         done = 0;
         if (e_wr) begin
            m_used++;
            done = (m_used == MB);
         end else if (pq[m_own].size() == 0) begin
            done = 1;
         end
         if (done) begin
            m_ptr = (m_own + 1) % N;
            w = winner(m_ptr);
            if (w >= 0) begin m_own = w; m_used = 0; end
            else m_act = 0;
         end
      end
      for (int i = 0; i < N; i++)
         if (e_rdy[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      cyc++;
      #1;
   endtask

   initial begin
      int n0;
      rst = 1'b1; fifo_full = 1'b0; req_valid = '0; req_data = '0;
      m_act = 0; m_own = 0; m_used = 0; m_ptr = 0;

      // Reset state
      clear_q();
      step(1, 0); step(1, 0);

      // T1: requester 2 writes A,B,C then drops valid
      pq[2].push_back(8'hA); pq[2].push_back(8'hB); pq[2].push_back(8'hC);
      for (int k = 0; k < 6; k++) step(0, 0);
      chk("t1_count", 32'(log_q.size()), 32'd3);
      for (int k = 0; k < 3 && k < log_q.size(); k++) begin
         chk("t1_id", 32'(log_q[k].id), 32'd2);
         chk("t1_data", 32'(log_q[k].d), 32'(8'hA + k));
      end
      if (log_q.size() == 3)
         chk("t1_back2back", 32'(log_q[2].cyc - log_q[0].cyc), 32'd2);

      // T6: owner 3 releases, then 0 and 3 valid -> 0 first
      pq[3].push_back(8'h33);
      for (int k = 0; k < 4; k++) step(0, 0);
      log_q.delete();
      pq[0].push_back(8'h01); pq[3].push_back(8'h34);
      for (int k = 0; k < 6; k++) step(0, 0);
      chk("t6_count", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("t6_first", 32'(log_q[0].id), 32'd0);
         chk("t6_second", 32'(log_q[1].id), 32'd3);
      end

      // T2: all valid, 4-word bursts, no bubbles
      step(1, 0); clear_q();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 20; j++) pq[i].push_back(8'(i*16 + j));
      for (int k = 0; k < 21; k++) step(0, 0);
      chk("t2_count", 32'(log_q.size()), 32'd20);
      for (int k = 0; k < log_q.size(); k++) begin
         chk("t2_owner", 32'(log_q[k].id), 32'((k / 4) % 4));
         chk("t2_data", 32'(log_q[k].d),
             32'(((k / 4) % 4) * 16 + (k / 16) * 4 + k % 4));
         if (k > 0) chk("t2_nobubble", 32'(log_q[k].cyc - log_q[k-1].cyc), 32'd1);
      end

      // T3: fifo full for 3 cycles after 2nd word
      step(1, 0); clear_q();
      for (int j = 0; j < 4; j++) pq[1].push_back(8'(8'h50 + j));
      step(0, 0); step(0, 0); step(0, 0);
      step(0, 1); step(0, 1); step(0, 1);
      for (int k = 0; k < 4; k++) step(0, 0);
      chk("t3_count", 32'(log_q.size()), 32'd4);
      for (int k = 0; k < log_q.size(); k++) begin
         chk("t3_id", 32'(log_q[k].id), 32'd1);
         chk("t3_data", 32'(log_q[k].d), 32'(8'h50 + k));
      end
      if (log_q.size() == 4)
         chk("t3_stall_gap", 32'(log_q[2].cyc - log_q[1].cyc), 32'd4);

      // T4: owner 0 drops after 2 words, hand-over to 1 without IDLE
      step(1, 0); clear_q();
      pq[0].push_back(8'h10); pq[0].push_back(8'h11);
      for (int j = 0; j < 3; j++) pq[1].push_back(8'(8'h20 + j));
      for (int k = 0; k < 8; k++) step(0, 0);
      chk("t4_count", 32'(log_q.size()), 32'd5);
      if (log_q.size() == 5) begin
         chk("t4_id1", 32'(log_q[1].id), 32'd0);
         chk("t4_id2", 32'(log_q[2].id), 32'd1);
         chk("t4_handover", 32'(log_q[2].cyc - log_q[1].cyc), 32'd2);
      end

      // T5: reset mid-burst of owner 2
      step(1, 0); clear_q();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 20; j++) pq[i].push_back(8'(i*16 + j));
      for (int k = 0; k < 11; k++) step(0, 0);
      if (log_q.size() > 0)
         chk("t5_pre_owner", 32'(log_q[log_q.size()-1].id), 32'd2);
      n0 = log_q.size();
      step(1, 0); step(1, 0);
      chk("t5_rst_nowrite", 32'(log_q.size()), 32'(n0));
      for (int k = 0; k < 3; k++) step(0, 0);
      if (log_q.size() > n0)
         chk("t5_post_owner", 32'(log_q[n0].id), 32'd0);
      else
         chk("t5_post_write", 32'(log_q.size()), 32'(n0 + 1));

      // Random traffic against the model
      step(1, 0); clear_q();
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0)
               for (int j = $urandom_range(1, 6); j > 0; j--)
                  pq[i].push_back(8'($urandom));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
